decode_stage_p: RTL and testbench
=================================

Name: decode_stage_p

Overview:
Parametrised decode stage plus D→E pipeline register for the 18-bit pipelined core.
- Extracts register and immediate fields from the instruction.
- Reads an internal bypassed register file.
- Detects load-use hazards and inserts bubbles on hazard or branch flush.
- Registers everything into the E stage, with valid tracking and saturating stall/bubble counters.

Parameters:
XLEN, 18, datapath/register width
IW, 33, instruction width
PCW, 9, PC width
NREG, 32, register count; AW = $clog2(NREG)
RS1_LSB, 23, LSB of rs1 field in instruction
RS2_LSB, 18, LSB of rs2 field
RD_LSB, 0, LSB of rd field
IMMW, 18, immediate field width, LSB at bit 0; must be ≤ XLEN
IMM_SIGNED, 0, 1 = sign-extend immediate to XLEN, 0 = zero-extend
CTRLW, 8, width of pass-through control bundle
CNTW, 16, performance counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
instr_d  in  IW  instruction in D
valid_d  in  1  instruction in D is real
pc_d, pc_plus4_d  in  PCW each  PC values in D
reg_write_d  in  1  D instruction writes rd
load_d  in  1  D instruction is a memory load (result from memory)
use_rs1_d, use_rs2_d  in  1 each  D instruction reads rs1 / rs2
ctrl_d  in  CTRLW  other control bits, passed through
stall_in  in  1  global hold from downstream
flush_d  in  1  discard D instruction (branch taken in E); level, held until accepted
reg_write_w  in  1  writeback enable
rd_w  in  AW  writeback address
result_w  in  XLEN  writeback data
valid_e, reg_write_e, load_e  out  1 each  registered E-stage flags
ctrl_e  out  CTRLW  registered control bundle
rd1_e, rd2_e, imm_e  out  XLEN each  registered operands and extended immediate
rs1_e, rs2_e, rd_e  out  AW each  registered register addresses
pc_e, pc_plus4_e  out  PCW each  registered PCs
bubble_e  out  1  E register holds an inserted bubble (registered)
stall_fd  out  1  hold F and D this cycle (combinational)
hazard  out  1  load-use hazard detected (combinational)
stall_cnt, bubble_cnt  out  CNTW each  saturating performance counters

Behaviour:
- Reset (rst=0, async): every registered output, including both counters, is 0. The register file is cleared to 0.
- Register file:
  - NREG×XLEN; r0 reads 0 and ignores writes.
  - Write at posedge when reg_write_w && rd_w≠0.
  - Combinational read with write-through: if reg_write_w && rd_w==rsX && rsX≠0, the read returns result_w.
- Fields:
  - rs1 = instr_d[RS1_LSB+:AW], rs2 = instr_d[RS2_LSB+:AW], rd = instr_d[RD_LSB+:AW].
  - imm = instr_d[IMMW-1:0], extended per IMM_SIGNED.
- Hazard (combinational):
  - hazard = valid_d && valid_e && load_e && rd_e≠0 && ((use_rs1_d && rs1==rd_e) || (use_rs2_d && rs2==rd_e)).
- stall_fd = stall_in || (hazard && !flush_d).
- E-register update priority at posedge:
  1. stall_in=1: hold all E outputs; bubble_e holds.
  2. else flush_d=1: load a bubble.
  3. else hazard=1: load a bubble.
  4. else: load the D values; valid_e=valid_d, bubble_e=0.
- A bubble means valid_e=0, reg_write_e=0, load_e=0, ctrl_e=CTRL_NOP, bubble_e=1. All other E fields are don't-care and are loaded as 0.
- flush_d is ignored while stall_in=1. The source keeps flush_d asserted until a cycle with stall_in=0.
- If valid_d=0 with no stall/flush/hazard, the D fields load normally with valid_e=0 and bubble_e=0.
- Latency: 1 cycle from D to E. A hazard stalls exactly 1 cycle: the next cycle has valid_e=0, so hazard clears.
- Counters, each +1 per cycle, saturating at 2^CNTW−1 (no wrap):
  - stall_cnt counts cycles with stall_fd=1.
  - bubble_cnt counts bubbles inserted (case 2 or 3).

Decomposition:
- Package decode_pkg:
  - default field-position localparams;
  - CTRL_NOP constant;
  - struct/typedef for the E-stage bundle (valid, reg_write, load, ctrl, rd1, rd2, imm, rs1, rs2, rd, pc, pc_plus4).
- One sub-module, regfile_bypass (parameters XLEN, NREG). It has two read ports with write-through, one write port, async active-low clear, and r0 hardwired to zero.

Test Plan:
- Reset mid-operation, with E loaded (valid_e=1, rd1_e=18'h3FFFF) → all outputs 0 immediately, without waiting for clk; counters 0.
- Write r5=18'h00ABC via W, then decode rs1=5 in the same cycle → rd1_e=18'h00ABC next edge (bypass). Write r0=7 → reading r0 gives 0.
- Load to r3 in E, then D has use_rs2_d=1, rs2=3 → hazard=1, stall_fd=1, one bubble (valid_e=0, bubble_e=1), bubble_cnt=1. The next cycle loads the instruction with valid_e=1.
- flush_d=1 together with hazard → bubble loaded, stall_fd=0. flush_d=1 under stall_in=1 for 3 cycles → E unchanged. Flush applies on the first cycle with stall_in=0.
- IMM_SIGNED=1, IMMW=12, imm field 12'h800 → imm_e=18'h3F800. IMM_SIGNED=0 → imm_e=18'h00800.
- CNTW=4, stall_in held for 20 cycles → stall_cnt saturates at 15 and never wraps.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared constants and types for the decode stage: default field positions,
// the control NOP pattern and the default-width E-stage bundle.
package decode_pkg;

    localparam int XLEN_DEF    = 18;
    localparam int IW_DEF      = 33;
    localparam int PCW_DEF     = 9;
    localparam int NREG_DEF    = 32;
    localparam int AW_DEF      = $clog2(NREG_DEF);
    localparam int RS1_LSB_DEF = 23;
    localparam int RS2_LSB_DEF = 18;
    localparam int RD_LSB_DEF  = 0;
    localparam int IMMW_DEF    = 18;
    localparam int CTRLW_DEF   = 8;
    localparam int CNTW_DEF    = 16;

    localparam logic [CTRLW_DEF-1:0] CTRL_NOP = '0;

    typedef struct packed {
        logic                 valid;
        logic                 reg_write;
        logic                 load;
        logic [CTRLW_DEF-1:0] ctrl;
        logic [XLEN_DEF-1:0]  rd1;
        logic [XLEN_DEF-1:0]  rd2;
        logic [XLEN_DEF-1:0]  imm;
        logic [AW_DEF-1:0]    rs1;
        logic [AW_DEF-1:0]    rs2;
        logic [AW_DEF-1:0]    rd;
        logic [PCW_DEF-1:0]   pc;
        logic [PCW_DEF-1:0]   pc_plus4;
    } e_bundle_t;

endpackage

// File: rtl/decode_stage_p_regfile.sv
// Register file with two write-through read ports; r0 always reads zero.
module regfile_bypass #(
    parameter  int XLEN = 18,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_we,
    input  logic [AW-1:0]   i_wa,
    input  logic [XLEN-1:0] i_wd,
    input  logic [AW-1:0]   i_ra1,
    input  logic [AW-1:0]   i_ra2,
    output logic [XLEN-1:0] o_rd1,
    output logic [XLEN-1:0] o_rd2
);

    logic [XLEN-1:0] r_mem [NREG];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_mem <= '{default: '0};
        end else if (i_we && i_wa != '0) begin
            r_mem[i_wa] <= i_wd;
        end
    end

    always_comb begin
        o_rd1 = r_mem[i_ra1];
        o_rd2 = r_mem[i_ra2];
        if (i_we && i_wa == i_ra1) o_rd1 = i_wd;
        if (i_we && i_wa == i_ra2) o_rd2 = i_wd;
        if (i_ra1 == '0) o_rd1 = '0;
        if (i_ra2 == '0) o_rd2 = '0;
    end

endmodule

// File: rtl/decode_stage_p.sv
// Decode stage: field extraction, bypassed register read, load-use hazard
// detection and the D->E pipeline register with saturating perf counters.
module decode_stage_p
    import decode_pkg::*;
#(
    parameter  int XLEN       = 18,
    parameter  int IW         = 33,
    parameter  int PCW        = 9,
    parameter  int NREG       = 32,
    parameter  int RS1_LSB    = 23,
    parameter  int RS2_LSB    = 18,
    parameter  int RD_LSB     = 0,
    parameter  int IMMW       = 18,
    parameter  bit IMM_SIGNED = 1'b0,
    parameter  int CTRLW      = 8,
    parameter  int CNTW       = 16,
    localparam int AW         = $clog2(NREG)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IW-1:0]    i_instr_d,
    input  logic             i_valid_d,
    input  logic [PCW-1:0]   i_pc_d,
    input  logic [PCW-1:0]   i_pc_plus4_d,
    input  logic             i_reg_write_d,
    input  logic             i_load_d,
    input  logic             i_use_rs1_d,
    input  logic             i_use_rs2_d,
    input  logic [CTRLW-1:0] i_ctrl_d,
    input  logic             i_stall_in,
    input  logic             i_flush_d,
    input  logic             i_reg_write_w,
    input  logic [AW-1:0]    i_rd_w,
    input  logic [XLEN-1:0]  i_result_w,
    output logic             o_valid_e,
    output logic             o_reg_write_e,
    output logic             o_load_e,
    output logic [CTRLW-1:0] o_ctrl_e,
    output logic [XLEN-1:0]  o_rd1_e,
    output logic [XLEN-1:0]  o_rd2_e,
    output logic [XLEN-1:0]  o_imm_e,
    output logic [AW-1:0]    o_rs1_e,
    output logic [AW-1:0]    o_rs2_e,
    output logic [AW-1:0]    o_rd_e,
    output logic [PCW-1:0]   o_pc_e,
    output logic [PCW-1:0]   o_pc_plus4_e,
    output logic             o_bubble_e,
    output logic             o_stall_fd,
    output logic             o_hazard,
    output logic [CNTW-1:0]  o_stall_cnt,
    output logic [CNTW-1:0]  o_bubble_cnt
);

    // Local copy of the E bundle so overridden widths stay consistent.
    typedef struct packed {
        logic             valid;
        logic             reg_write;
        logic             load;
        logic [CTRLW-1:0] ctrl;
        logic [XLEN-1:0]  rd1;
        logic [XLEN-1:0]  rd2;
        logic [XLEN-1:0]  imm;
        logic [AW-1:0]    rs1;
        logic [AW-1:0]    rs2;
        logic [AW-1:0]    rd;
        logic [PCW-1:0]   pc;
        logic [PCW-1:0]   pc_plus4;
    } e_t;

    logic [AW-1:0]   w_rs1, w_rs2, w_rd;
    logic [XLEN-1:0] w_rd1, w_rd2, w_imm;
    logic            w_hazard, w_stall_fd, w_bubble;
    e_t              w_d, w_nop, r_e;
    logic            r_bubble;
    logic [CNTW-1:0] r_stall_cnt, r_bubble_cnt;

    assign w_rs1 = i_instr_d[RS1_LSB +: AW];
    assign w_rs2 = i_instr_d[RS2_LSB +: AW];
    assign w_rd  = i_instr_d[RD_LSB +: AW];
    assign w_imm = IMM_SIGNED ? XLEN'($signed(i_instr_d[IMMW-1:0]))
                              : XLEN'(i_instr_d[IMMW-1:0]);

    regfile_bypass #(.XLEN(XLEN), .NREG(NREG)) u_rf (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_we  (i_reg_write_w),
        .i_wa  (i_rd_w),
        .i_wd  (i_result_w),
        .i_ra1 (w_rs1),
        .i_ra2 (w_rs2),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2)
    );

    assign w_hazard = i_valid_d && r_e.valid && r_e.load && (r_e.rd != '0) &&
                      ((i_use_rs1_d && w_rs1 == r_e.rd) ||
                       (i_use_rs2_d && w_rs2 == r_e.rd));
    assign w_stall_fd = i_stall_in || (w_hazard && !i_flush_d);
    assign w_bubble   = !i_stall_in && (i_flush_d || w_hazard);

    always_comb begin
        w_d           = '0;
        w_d.valid     = i_valid_d;
        w_d.reg_write = i_reg_write_d;
        w_d.load      = i_load_d;
        w_d.ctrl      = i_ctrl_d;
        w_d.rd1       = w_rd1;
        w_d.rd2       = w_rd2;
        w_d.imm       = w_imm;
        w_d.rs1       = w_rs1;
        w_d.rs2       = w_rs2;
        w_d.rd        = w_rd;
        w_d.pc        = i_pc_d;
        w_d.pc_plus4  = i_pc_plus4_d;
        w_nop         = '0;
        w_nop.ctrl    = CTRLW'(CTRL_NOP);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_e          <= '0;
            r_bubble     <= 1'b0;
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (!i_stall_in) begin
                r_e      <= w_bubble ? w_nop : w_d;
                r_bubble <= w_bubble;
            end
            if (w_stall_fd && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_bubble && r_bubble_cnt != '1)
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign o_valid_e     = r_e.valid;
    assign o_reg_write_e = r_e.reg_write;
    assign o_load_e      = r_e.load;
    assign o_ctrl_e      = r_e.ctrl;
    assign o_rd1_e       = r_e.rd1;
    assign o_rd2_e       = r_e.rd2;
    assign o_imm_e       = r_e.imm;
    assign o_rs1_e       = r_e.rs1;
    assign o_rs2_e       = r_e.rs2;
    assign o_rd_e        = r_e.rd;
    assign o_pc_e        = r_e.pc;
    assign o_pc_plus4_e  = r_e.pc_plus4;
    assign o_bubble_e    = r_bubble;
    assign o_stall_fd    = w_stall_fd;
    assign o_hazard      = w_hazard;
    assign o_stall_cnt   = r_stall_cnt;
    assign o_bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_decode_stage_p.sv
// Bench for decode_stage_p: default instance plus a signed-imm / 4-bit counter
// instance driven from the same stimulus, checked against a reference model.
module tb_decode_stage_p;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [32:0] instr;
    logic        vd, rw_d, ld_d, u1, u2, stall, flush, rw_w;
    logic [8:0]  pc, pc4;
    logic [7:0]  ctrl;
    logic [4:0]  rdw;
    logic [17:0] resw;

    logic        valid_e, reg_write_e, load_e, bubble_e, stall_fd, hazard;
    logic [7:0]  ctrl_e;
    logic [17:0] rd1_e, rd2_e, imm_e;
    logic [4:0]  rs1_e, rs2_e, rd_e;
    logic [8:0]  pc_e, pc_plus4_e;
    logic [15:0] stall_cnt, bubble_cnt;

    logic        s_valid_e, s_reg_write_e, s_load_e, s_bubble_e, s_stall_fd, s_hazard;
    logic [7:0]  s_ctrl_e;
    logic [17:0] s_rd1_e, s_rd2_e, s_imm_e;
    logic [4:0]  s_rs1_e, s_rs2_e, s_rd_e;
    logic [8:0]  s_pc_e, s_pc_plus4_e;
    logic [3:0]  s_stall_cnt, s_bubble_cnt;

    always #5 clk = ~clk;

    decode_stage_p u_dut (
        .i_clk(clk), .i_rst(rst), .i_instr_d(instr), .i_valid_d(vd),
        .i_pc_d(pc), .i_pc_plus4_d(pc4), .i_reg_write_d(rw_d), .i_load_d(ld_d),
        .i_use_rs1_d(u1), .i_use_rs2_d(u2), .i_ctrl_d(ctrl), .i_stall_in(stall),
        .i_flush_d(flush), .i_reg_write_w(rw_w), .i_rd_w(rdw), .i_result_w(resw),
        .o_valid_e(valid_e), .o_reg_write_e(reg_write_e), .o_load_e(load_e),
        .o_ctrl_e(ctrl_e), .o_rd1_e(rd1_e), .o_rd2_e(rd2_e), .o_imm_e(imm_e),
        .o_rs1_e(rs1_e), .o_rs2_e(rs2_e), .o_rd_e(rd_e), .o_pc_e(pc_e),
        .o_pc_plus4_e(pc_plus4_e), .o_bubble_e(bubble_e), .o_stall_fd(stall_fd),
        .o_hazard(hazard), .o_stall_cnt(stall_cnt), .o_bubble_cnt(bubble_cnt)
    );

    decode_stage_p #(.IMMW(12), .IMM_SIGNED(1'b1), .CNTW(4)) u_dut_s (
        .i_clk(clk), .i_rst(rst), .i_instr_d(instr), .i_valid_d(vd),
        .i_pc_d(pc), .i_pc_plus4_d(pc4), .i_reg_write_d(rw_d), .i_load_d(ld_d),
        .i_use_rs1_d(u1), .i_use_rs2_d(u2), .i_ctrl_d(ctrl), .i_stall_in(stall),
        .i_flush_d(flush), .i_reg_write_w(rw_w), .i_rd_w(rdw), .i_result_w(resw),
        .o_valid_e(s_valid_e), .o_reg_write_e(s_reg_write_e), .o_load_e(s_load_e),
        .o_ctrl_e(s_ctrl_e), .o_rd1_e(s_rd1_e), .o_rd2_e(s_rd2_e), .o_imm_e(s_imm_e),
        .o_rs1_e(s_rs1_e), .o_rs2_e(s_rs2_e), .o_rd_e(s_rd_e), .o_pc_e(s_pc_e),
        .o_pc_plus4_e(s_pc_plus4_e), .o_bubble_e(s_bubble_e), .o_stall_fd(s_stall_fd),
        .o_hazard(s_hazard), .o_stall_cnt(s_stall_cnt), .o_bubble_cnt(s_bubble_cnt)
    );

    typedef struct {
        e_bundle_t   e;
        logic        bub;
        logic [15:0] sc, bc;
        logic [3:0]  sc4, bc4;
        logic [17:0] imm_s;
    } exp_t;

    exp_t        q[$];
    e_bundle_t   m_e;
    logic        m_bub;
    logic [15:0] m_sc, m_bc;
    logic [3:0]  m_sc4, m_bc4;
    logic [17:0] m_imm_s;
    logic [17:0] m_rf [32];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [17:0] rf_read(input logic [4:0] a);
        if (a == 5'd0) return 18'd0;
        if (rw_w && rdw == a) return resw;
        return m_rf[a];
    endfunction

    task automatic model_reset();
        m_e = '0; m_bub = 1'b0; m_sc = '0; m_bc = '0;
        m_sc4 = '0; m_bc4 = '0; m_imm_s = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
    endtask

    function automatic logic [32:0] mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [4:0] rd, input logic [17:0] imm);
        logic [32:0] v;
        v        = '0;
        v[17:0]  = imm;
        v[4:0]   = rd;
        v[22:18] = rs2;
        v[27:23] = rs1;
        return v;
    endfunction

    task automatic clear_in();
        instr = '0; vd = 0; rw_d = 0; ld_d = 0; u1 = 0; u2 = 0; ctrl = '0;
        pc = '0; pc4 = '0; stall = 0; flush = 0; rw_w = 0; rdw = '0; resw = '0;
    endtask

    task automatic set_d(input logic [32:0] in, input logic v, input logic ld,
                         input logic rw, input logic a1, input logic a2);
        instr = in; vd = v; ld_d = ld; rw_d = rw; u1 = a1; u2 = a2;
        pc = 9'($urandom); pc4 = 9'($urandom); ctrl = 8'($urandom);
    endtask

    task automatic step();
        logic [4:0] rs1, rs2;
        logic       haz, sfd, bub;
        exp_t       x;
        rs1 = instr[27:23];
        rs2 = instr[22:18];
        haz = vd && m_e.valid && m_e.load && (m_e.rd != 5'd0) &&
              ((u1 && rs1 == m_e.rd) || (u2 && rs2 == m_e.rd));
        sfd = stall || (haz && !flush);
        bub = !stall && (flush || haz);
        #1;
        check("hazard", hazard, haz);
        check("stall_fd", stall_fd, sfd);
        x.e = m_e; x.bub = m_bub; x.imm_s = m_imm_s;
        if (bub) begin
            x.e = '0; x.e.ctrl = CTRL_NOP; x.bub = 1'b1; x.imm_s = '0;
        end else if (!stall) begin
            x.e.valid = vd; x.e.reg_write = rw_d; x.e.load = ld_d; x.e.ctrl = ctrl;
            x.e.rd1 = rf_read(rs1); x.e.rd2 = rf_read(rs2); x.e.imm = instr[17:0];
            x.e.rs1 = rs1; x.e.rs2 = rs2; x.e.rd = instr[4:0];
            x.e.pc = pc; x.e.pc_plus4 = pc4; x.bub = 1'b0;
            x.imm_s = {{6{instr[11]}}, instr[11:0]};
        end
        x.sc  = (sfd && m_sc  != 16'hFFFF) ? m_sc  + 16'd1 : m_sc;
        x.bc  = (bub && m_bc  != 16'hFFFF) ? m_bc  + 16'd1 : m_bc;
        x.sc4 = (sfd && m_sc4 != 4'hF)     ? m_sc4 + 4'd1  : m_sc4;
        x.bc4 = (bub && m_bc4 != 4'hF)     ? m_bc4 + 4'd1  : m_bc4;
        q.push_back(x);
        if (rw_w && rdw != 5'd0) m_rf[rdw] = resw;
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check("queue_empty", 1, 0);
        end else begin
            x = q.pop_front();
            check("valid_e", valid_e, x.e.valid);
            check("reg_write_e", reg_write_e, x.e.reg_write);
            check("load_e", load_e, x.e.load);
            check("ctrl_e", ctrl_e, x.e.ctrl);
            check("rd1_e", rd1_e, x.e.rd1);
            check("rd2_e", rd2_e, x.e.rd2);
            check("imm_e", imm_e, x.e.imm);
            check("rs1_e", rs1_e, x.e.rs1);
            check("rs2_e", rs2_e, x.e.rs2);
            check("rd_e", rd_e, x.e.rd);
            check("pc_e", pc_e, x.e.pc);
            check("pc_plus4_e", pc_plus4_e, x.e.pc_plus4);
            check("bubble_e", bubble_e, x.bub);
            check("stall_cnt", stall_cnt, x.sc);
            check("bubble_cnt", bubble_cnt, x.bc);
            check("s_imm_e", s_imm_e, x.imm_s);
            check("s_stall_cnt", s_stall_cnt, x.sc4);
            check("s_bubble_cnt", s_bubble_cnt, x.bc4);
            m_e = x.e; m_bub = x.bub; m_sc = x.sc; m_bc = x.bc;
            m_sc4 = x.sc4; m_bc4 = x.bc4; m_imm_s = x.imm_s;
        end
    endtask

    initial begin
        rst = 1'b0;
        clear_in();
        model_reset();
        #12;
        check("rst_valid_e", valid_e, 0);
        check("rst_bubble_e", bubble_e, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_bubble_cnt", bubble_cnt, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // write r5 while decoding rs1=5: write-through
        set_d(mk(5'd5, 5'd0, 5'd1, 18'h0), 1, 0, 1, 1, 0);
        rw_w = 1; rdw = 5'd5; resw = 18'h00ABC;
        step();
        check("bypass_r5", rd1_e, 18'h00ABC);
        // write r0 = 7 while reading r0
        set_d(mk(5'd0, 5'd5, 5'd2, 18'h0), 1, 0, 1, 1, 1);
        rw_w = 1; rdw = 5'd0; resw = 18'd7;
        step();
        check("r0_zero", rd1_e, 18'd0);
        check("r5_stored", rd2_e, 18'h00ABC);
        rw_w = 0;

        // load-use hazard on rs2
        set_d(mk(5'd0, 5'd0, 5'd3, 18'h0), 1, 1, 1, 0, 0);
        step();
        set_d(mk(5'd1, 5'd3, 5'd4, 18'h0), 1, 0, 1, 0, 1);
        step();
        check("haz_bubble", bubble_e, 1);
        check("haz_bubble_cnt", bubble_cnt, 1);
        step();
        check("haz_release_valid", valid_e, 1);

        // flush with a hazard present
        set_d(mk(5'd0, 5'd0, 5'd7, 18'h0), 1, 1, 1, 0, 0);
        step();
        set_d(mk(5'd7, 5'd0, 5'd6, 18'h0), 1, 0, 1, 1, 0);
        flush = 1;
        step();
        flush = 0;

        // flush held under stall: E holds for 3 cycles, then flush applies
        set_d(mk(5'd2, 5'd2, 5'd8, 18'h155), 1, 0, 1, 1, 1);
        step();
        set_d(mk(5'd9, 5'd9, 5'd9, 18'h2AA), 1, 0, 1, 1, 1);
        stall = 1; flush = 1;
        repeat (3) step();
        stall = 0;
        step();
        check("flush_after_stall", bubble_e, 1);
        flush = 0;

        // immediate extension: 12'h800
        set_d(mk(5'd0, 5'd0, 5'd0, 18'h00800), 1, 0, 0, 0, 0);
        step();
        check("imm_zext", imm_e, 18'h00800);
        check("imm_sext", s_imm_e, 18'h3F800);

        // saturation of the 4-bit stall counter
        stall = 1;
        repeat (20) step();
        check("stall_sat4", s_stall_cnt, 4'hF);
        stall = 0;

        // random traffic with tight register indices to provoke hazards
        for (int i = 0; i < 40; i++) begin
            set_d(mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 18'($urandom)),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            instr[32:28] = 5'($urandom);
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 7) == 0);
            rw_w  = 1'($urandom);
            rdw   = 5'($urandom_range(0, 3));
            resw  = 18'($urandom);
            step();
        end
        clear_in();

        // async reset with E loaded
        set_d(mk(5'd9, 5'd0, 5'd1, 18'h0), 1, 0, 1, 1, 0);
        rw_w = 1; rdw = 5'd9; resw = 18'h3FFFF;
        step();
        check("pre_rst_rd1", rd1_e, 18'h3FFFF);
        rw_w = 0;
        rst = 1'b0;
        #1;
        check("arst_valid_e", valid_e, 0);
        check("arst_rd1_e", rd1_e, 0);
        check("arst_stall_cnt", stall_cnt, 0);
        check("arst_bubble_cnt", bubble_cnt, 0);
        model_reset();
        #1;
        rst = 1'b1;
        step();
        check("rf_cleared", rd1_e, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
